// File: rtl/dot_product_ctrl.sv
// rtl/dot_product_ctrl.sv - dot-product sequencer: launches one mem_reader pass and accumulates products
//
// Launches a mem_reader pass on start, accumulates mem1_data*mem2_data for each
// valid element pair, verifies the element count and returns the sum through a
// valid/ready result handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   pass request (sampled only in IDLE)
//   busy                    high whenever not IDLE
//   start_reading           one-cycle launch pulse to mem_reader
//   reading_done            pass-complete indication from mem_reader
//   data_valid              mem1_data/mem2_data hold a valid element pair
//   mem1_data, mem2_data    operand elements (unsigned)
//   elem_count              elements accepted in the current pass
//   result, result_valid    dot product and its valid flag
//   result_ready            consumer accepts the result
//   error                   pass ended abnormally (count mismatch or timeout)

`timescale 1ns/1ps

module dot_product_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
  parameter int TIMEOUT      = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               start_reading,
  input  logic                               reading_done,
  input  logic                               data_valid,
  input  logic [DATA_WIDTH-1:0]              mem1_data,
  input  logic [DATA_WIDTH-1:0]              mem2_data,
  output logic [$clog2(VECTOR_WIDTH+1)-1:0]  elem_count,
  output logic [ACC_WIDTH-1:0]               result,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic                               error
);

  localparam int CW = $clog2(VECTOR_WIDTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int PW = 2*DATA_WIDTH;

  localparam logic [CW-1:0] VW_C    = CW'(VECTOR_WIDTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_n;
  logic [ACC_WIDTH-1:0] acc_n;
  logic [CW-1:0]   cnt_n;
  logic            err_n;
  logic [PW-1:0]   prod;

  // Zero-extend before multiplying so the product is full-width unsigned.
  assign prod = {{DATA_WIDTH{1'b0}}, mem1_data} * {{DATA_WIDTH{1'b0}}, mem2_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      result        <= '0;
      elem_count    <= '0;
      error         <= 1'b0;
      busy          <= 1'b0;
      start_reading <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_n;
      result        <= acc_n;
      elem_count    <= cnt_n;
      error         <= err_n;
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      busy          <= (state_next != IDLE);
      start_reading <= (state_next == LAUNCH);
      result_valid  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    timer_n    = timer;
    acc_n      = result;
    cnt_n      = elem_count;
    err_n      = error;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LAUNCH;
          timer_n    = '0;
          acc_n      = '0;
          cnt_n      = '0;
          err_n      = 1'b0;
        end
      end

      LAUNCH: state_next = ACCUM;

      ACCUM: begin
        if (data_valid) begin
          timer_n = '0;
          if (elem_count < VW_C) begin
            acc_n = result + ACC_WIDTH'(prod);
            cnt_n = elem_count + 1'b1;
          end else begin
            // Surplus element: dropped, but the pass is flagged.
            err_n = 1'b1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end

        // cnt_n already includes a same-cycle element.
        if (reading_done) begin
          state_next = DONE;
          if (cnt_n != VW_C) err_n = 1'b1;
        end else if (!data_valid && timer == TO_LAST) begin
          state_next = DONE;
          err_n      = 1'b1;
        end
      end

      DONE: begin
        if (result_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
